// File: rtl/iir_pkg.sv
// ============================================================================
// Module      : iir_pkg
// Description : Constants and types shared by the IIR sample source and the
//               optimised IIR datapath.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package iir_pkg;

  localparam int c_DATA_W = 24;
  localparam int c_ADDR_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_GAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } src_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iir_rate_div.sv
// ============================================================================
// Module      : iir_rate_div
// Description : Free-running modulo-RATE_DIV counter with synchronous clear;
//               tick is high while the count is zero.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module iir_rate_div
  import iir_pkg::*;
#(
  parameter int RATE_DIV = 1,
  parameter int CNT_W    = cnt_width(RATE_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] c_TOP = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_TOP)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/iir_stream_src.sv
// ============================================================================
// Module      : iir_stream_src
// Description : Hardware sample source for opti_top: start pulse, ROM-driven
//               sample stream at a programmable rate, done pulse per pass.
//               Define IIR_SRC_LOOP_EN for continuous playback with stop.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module iir_stream_src
  import iir_pkg::*;
#(
  parameter int DATA_W    = c_DATA_W,
  parameter int ADDR_W    = c_ADDR_W,
  parameter int N_SAMPLES = 2048,
  parameter int START_GAP = 4,
  parameter int RATE_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              start,
  output logic [DATA_W-1:0] data_in,
  output logic              data_in_valid,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W  = ADDR_W + 1;
  localparam int GAP_W  = cnt_width(START_GAP);
  localparam int RCNT_W = cnt_width(RATE_DIV);

  localparam logic [IDX_W-1:0]  c_N          = IDX_W'(N_SAMPLES);
  localparam logic [IDX_W-1:0]  c_LAST       = IDX_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [GAP_W-1:0]  c_GAP_LOAD   = GAP_W'(START_GAP - 1);
  localparam logic [RCNT_W-1:0] c_PRE        = RCNT_W'((RATE_DIV > 1) ? RATE_DIV - 2 : 0);

  src_state_t        r_state;
  logic [GAP_W-1:0]  r_gap;
  logic [IDX_W-1:0]  r_idx;    // next sample to emit; c_N once a pass is exhausted
  logic [ADDR_W-1:0] r_fidx;   // next sample to fetch from the ROM
  logic              r_pend;   // last sample of a pass was emitted on the previous edge

  logic              w_run;
  logic              w_slot;
  logic              w_adv;
  logic              w_pre_gap;
  logic              w_wrap;
  logic              w_tick;
  logic [RCNT_W-1:0] w_rcnt;

  // Cadence runs from the final GAP cycle onward, and through DONE when looping.
  assign w_run  = ((r_state == ST_GAP) && (r_gap == '0)) ||
                  (r_state == ST_STREAM) ||
                  ((r_state == ST_DONE) && (r_idx != c_N));
  assign w_slot = w_run && w_tick && (r_idx != c_N);

  // The ROM address must be presented two edges ahead of each emission; with
  // RATE_DIV=1 the first advance therefore falls one edge before the cadence.
  assign w_pre_gap = (RATE_DIV == 1) &&
                     (((r_state == ST_GAP) && (r_gap == GAP_W'(1))) ||
                      ((r_state == ST_START) && (START_GAP == 1)));
  assign w_adv     = (w_run && (w_rcnt == c_PRE)) || w_pre_gap;

  iir_rate_div #(
    .RATE_DIV (RATE_DIV),
    .CNT_W    (RCNT_W)
  ) u_rate_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!w_run),
    .cnt   (w_rcnt),
    .tick  (w_tick)
  );

`ifdef IIR_SRC_LOOP_EN
  logic r_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_stop <= 1'b0;
    end else if (stop) begin
      r_stop <= 1'b1;
    end
  end

  assign w_wrap = !(r_stop || stop);
`else
  logic w_unused_stop;

  assign w_unused_stop = stop;
  assign w_wrap        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_gap         <= '0;
      r_idx         <= '0;
      r_fidx        <= '0;
      r_pend        <= 1'b0;
      start         <= 1'b0;
      data_in       <= '0;
      data_in_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      start         <= 1'b0;
      done          <= 1'b0;
      data_in_valid <= 1'b0;
      r_pend        <= 1'b0;

      if (w_slot) begin
        data_in       <= rom_data;
        data_in_valid <= 1'b1;
        if (r_idx == c_LAST) begin
          r_idx  <= w_wrap ? '0 : c_N;
          r_pend <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end

      if (w_adv) begin
        if (r_fidx == c_LAST_ADDR) begin
          r_fidx <= w_wrap ? '0 : r_fidx;
        end else begin
          r_fidx <= r_fidx + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_state <= ST_START;
            start   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_START: begin
          r_state <= ST_GAP;
          r_gap   <= c_GAP_LOAD;
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_state <= ST_STREAM;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        ST_STREAM: begin
          if (r_pend) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (r_pend) begin
            done <= 1'b1;
          end else if (r_idx == c_N) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            r_idx   <= '0;
            r_fidx  <= '0;
            data_in <= '0;
          end else begin
            r_state <= ST_STREAM;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = r_fidx;

endmodule

`default_nettype wire

// File: doc/iir_stream_src.md
# iir_stream_src

Hardware sample source for the optimised IIR datapath (`opti_top`). It does in RTL what the bench stimulus does:

- issues the one-cycle `start` pulse;
- reads Q2.22 test samples from a synchronous ROM;
- drives `data_in`/`data_in_valid` at a programmable rate;
- reports completion.

It sits directly upstream of `opti_top` on FPGA builds, so the filter can be exercised without a simulator.

## Interface
Parameters:
- `DATA_W`, 24, sample width (Q2.22, two's complement)
- `ADDR_W`, 11, ROM address width
- `N_SAMPLES`, 2048, samples per pass; 1..2^ADDR_W
- `START_GAP`, 4, idle cycles between the `start` pulse and the first sample; ≥1
- `RATE_DIV`, 1, cycles per sample; ≥1 (1 = back-to-back valid)

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `go` in 1: level, sampled in IDLE only; launches a pass
- `stop` in 1: end-of-loop request; used only with `IIR_SRC_LOOP_EN`
- `rom_addr` out ADDR_W: sample ROM address
- `rom_data` in DATA_W: ROM read data, valid 1 cycle after `rom_addr`
- `start` out 1: one-cycle pulse to `opti_top.start`
- `data_in` out DATA_W: sample to `opti_top.data_in`
- `data_in_valid` out 1: sample qualifier
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at the end of each pass

## Operation
States are IDLE, START, GAP, STREAM and DONE.

- **IDLE**
  - All outputs are 0 and `rom_addr` = 0.
  - `go`=1 moves to START.
- **START**
  - `start`=1 for exactly one cycle, then GAP.
  - The GAP counter loads START_GAP-1.
- **GAP**
  - Lasts START_GAP cycles.
  - `rom_addr` = 0, so sample 0 is prefetched.
  - Moves to STREAM when the counter reaches 0.
- **STREAM**
  - The sample index k runs 0..N_SAMPLES-1.
  - A rate counter counts 0..RATE_DIV-1. At count 0, `data_in_valid`=1 and `data_in` = ROM[k].
  - `rom_addr` is advanced in time that ROM[k+1] is registered before its emission slot, including when RATE_DIV=1.
  - `data_in` holds its last value between valid cycles. `data_in_valid` is 0 outside emission slots.
  - After the emission of k = N_SAMPLES-1, the state moves to DONE.
- **DONE**
  - `done`=1 for one cycle.
  - Returns to IDLE (one-shot build) or follows the loop rules in Configuration.
- Arithmetic and data handling:
  - Samples pass through unmodified. There is no rounding or saturation.
  - The index counter is ADDR_W+1 bits wide, so N_SAMPLES = 2^ADDR_W does not alias.
- `go` while `busy`=1 is ignored. `go` held high through DONE starts a new pass on the IDLE cycle that follows.
- Reset:
  - Asserting `rst_n` low at any time forces IDLE immediately. All outputs go to 0 and counters clear.
  - No partial sample or stray `start` may follow reset release.

## Timing
Let `go` be sampled high at edge T.

- `start` is high during cycle T+1.
- The first `data_in_valid` occurs at T+2+START_GAP.
- Sample k is emitted at T+2+START_GAP+k·RATE_DIV.
- `done` occurs at (last emission)+1. For the defaults this is T+2054.
- `busy` rises at T+1 and falls the cycle after `done`.
- `rom_addr` changes only on rising edges. The ROM is strictly 1-cycle synchronous read; no combinational read path is allowed.

## Configuration
Macro: `IIR_SRC_LOOP_EN`.

- **Defined (continuous playback)**
  - DONE wraps to STREAM with k = 0.
  - No new `start` pulse is issued. The rate cadence continues unbroken across the wrap, so the sample spacing at the boundary equals RATE_DIV.
  - `done` pulses on each wrap.
  - A `stop` seen high at any point in a pass is latched. That pass completes, and then the block goes DONE → IDLE.
- **Undefined (one-shot)**
  - Single pass per `go`.
  - The `stop` port remains but is ignored.
  - No latch is synthesised.

## Structure
- Shared package `iir_pkg` holds:
  - the DATA_W and ADDR_W constants shared with `opti_top`;
  - the `src_state_t` enum covering IDLE, START, GAP, STREAM and DONE.
- One sub-module, `iir_rate_div`:
  - a parameterised RATE_DIV tick counter with a synchronous clear;
  - outputs a `tick` at count 0.
- The ROM is external. The bench uses a behavioural model loaded from `test_signal.hex`.

## Test plan
1. Defaults with ROM[k] = k. Pulse `go` → `start` at T+1; first valid at T+6 with `data_in` = 0x000000; 2048 consecutive valids; last sample 0x0007FF; `done` at T+2054.
2. RATE_DIV=3, N_SAMPLES=8 → valids exactly 3 cycles apart; `data_in` stable in between; `done` 1 cycle after the 8th valid.
3. Reset at sample 100, held 2 cycles → all outputs 0 immediately, IDLE. A fresh `go` restarts from sample 0 with a new `start` pulse.
4. `go` held high continuously; ROM holding 0x800000 and 0x7FFFFF → second pass starts only after IDLE; sign and extreme codes pass unchanged.
5. `IIR_SRC_LOOP_EN` with N_SAMPLES=4 and RATE_DIV=1 → sequence 0,1,2,3,0,1… with no gap. `done` at every wrap. `stop` mid-pass 2 → pass 2 completes, then IDLE. Only one `start` pulse in the whole run.
6. End-to-end: the block drives `opti_top` with the reference vectors → captured `data_out` matches `reference_output.hex` with 0 errors.
